// File: rtl/bin2dec_seg_if.sv
// bin2dec_seg_if: request/result bundle between a requester and bin2dec_seg.
//   start        conversion request (requester -> converter)
//   i_bin        32-bit unsigned value to convert
//   o_busy       conversion in progress
//   o_done       one-cycle pulse when the result registers update
//   o_ovf        last converted value exceeded 99_999_999
//   o_data       64-bit display word for seg7.i_data
//   o_disp_mode  display mode for seg7.disp_mode
interface bin2dec_seg_if;
    logic        start;
    logic [31:0] i_bin;
    logic        o_busy;
    logic        o_done;
    logic        o_ovf;
    logic [63:0] o_data;
    logic        o_disp_mode;

    modport master (
        output start, i_bin,
        input  o_busy, o_done, o_ovf, o_data, o_disp_mode
    );

    modport slave (
        input  start, i_bin,
        output o_busy, o_done, o_ovf, o_data, o_disp_mode
    );
endinterface

// File: rtl/bin2dec_seg.sv
// bin2dec_seg: iterative double-dabble binary-to-decimal converter feeding seg7.
//   clk   system clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   slave side of bin2dec_seg_if (start/i_bin in; busy/done/ovf/data/mode out)
// BLANK_LZ=1: o_data holds 8 active-low segment bytes with leading-zero blanking.
// BLANK_LZ=0: o_data[31:0] holds 8 packed BCD nibbles, upper half zero.
module bin2dec_seg #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic          clk,
    input  logic          rstn,
    bin2dec_seg_if.slave  bus
);

    localparam int unsigned BIN_W       = 32;
    localparam int unsigned BCD_DIGITS  = 10;
    localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
    localparam int unsigned DISP_DIGITS = 8;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned CNT_W       = 5;

    localparam logic [BIN_W-1:0]  MAX_DEC   = BIN_W'(99_999_999);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(31);
    localparam logic [DATA_W-1:0] DATA_RST  = BLANK_LZ ? 64'hFFFF_FFFF_FFFF_FFC0
                                                       : 64'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state;
    logic [BIN_W-1:0]    bin_sr;
    logic [BCD_W-1:0]    bcd;
    logic [CNT_W-1:0]    iter;
    logic                ovf_pend;
    logic                busy_q;
    logic                done_q;
    logic                ovf_q;
    logic [DATA_W-1:0]   data_q;

    logic [BCD_W-1:0]    bcd_adj;
    logic [DATA_W-1:0]   disp_next;

    // Active-low segment pattern for one decimal digit, dp off.
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    // Double-dabble correction: any digit >= 5 would overflow past 9 on the shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
    end

    // Display word from the finished accumulator; digits 8-9 only matter via ovf_pend.
    always_comb begin
        logic       seen;
        logic [3:0] nib;
        disp_next = '0;
        seen      = 1'b0;
        nib       = '0;
        if (BLANK_LZ) begin
            // Scan from the top so 'seen' marks the first nonzero digit downward.
            for (int i = int'(DISP_DIGITS) - 1; i >= 0; i--) begin
                nib = bcd[4*i +: 4];
                if (nib != 4'd0) begin
                    seen = 1'b1;
                end
                if (ovf_pend) begin
                    disp_next[8*i +: 8] = 8'hBF;
                end else if (!seen && (i != 0)) begin
                    disp_next[8*i +: 8] = 8'hFF;
                end else begin
                    disp_next[8*i +: 8] = seg_code(nib);
                end
            end
        end else begin
            disp_next[31:0] = ovf_pend ? 32'hFFFF_FFFF : bcd[31:0];
        end
    end

    // Conversion FSM with registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            bin_sr   <= '0;
            bcd      <= '0;
            iter     <= '0;
            ovf_pend <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            data_q   <= DATA_RST;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_sr   <= bus.i_bin;
                        bcd      <= '0;
                        iter     <= '0;
                        ovf_pend <= (bus.i_bin > MAX_DEC);
                        busy_q   <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd    <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
                    bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
                    iter   <= iter + CNT_W'(1);
                    if (iter == LAST_ITER) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    data_q <= disp_next;
                    ovf_q  <= ovf_pend;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_ovf       = ovf_q;
    assign bus.o_data      = data_q;
    assign bus.o_disp_mode = BLANK_LZ;

endmodule

// File: tb/tb_bin2dec_seg.sv
// tb_bin2dec_seg: directed self-checking bench for bin2dec_seg, both BLANK_LZ modes
// side by side on a shared clock, reset and stimulus.
`timescale 1ns/1ps
module tb_bin2dec_seg;

    logic clk;
    logic rstn;

    int n_checks;
    int n_errors;

    bin2dec_seg_if bus_raw ();
    bin2dec_seg_if bus_bcd ();

    bin2dec_seg #(.BLANK_LZ(1'b1)) u_raw (.clk(clk), .rstn(rstn), .bus(bus_raw));
    bin2dec_seg #(.BLANK_LZ(1'b0)) u_bcd (.clk(clk), .rstn(rstn), .bus(bus_bcd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [31:0] v);
        bus_raw.start = s;
        bus_raw.i_bin = v;
        bus_bcd.start = s;
        bus_bcd.i_bin = v;
    endtask

    // Count edges until o_done is seen (sampled 1 ns after each edge), bounded.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus_raw.o_done && n < 100);
        check("done_same_edge", 64'(bus_bcd.o_done), 64'(bus_raw.o_done));
    endtask

    task automatic check_result(input string tag, input logic [63:0] raw,
                                input logic [63:0] bcd, input logic ovf);
        check({tag, "_raw"}, bus_raw.o_data, raw);
        check({tag, "_bcd"}, bus_bcd.o_data, bcd);
        check({tag, "_ovf_raw"}, 64'(bus_raw.o_ovf), 64'(ovf));
        check({tag, "_ovf_bcd"}, 64'(bus_bcd.o_ovf), 64'(ovf));
    endtask

    // One full conversion; i_bin is scrambled after the accept edge.
    task automatic run(input string tag, input logic [31:0] v, input logic [63:0] raw,
                       input logic [63:0] bcd, input logic ovf);
        int n;
        @(negedge clk);
        drive(1'b1, v);
        @(posedge clk);
        #1;
        check({tag, "_busy_accept"}, 64'(bus_raw.o_busy), 64'd1);
        drive(1'b0, 32'hDEAD_BEEF);
        wait_done(n);
        check({tag, "_latency"}, 64'(n), 64'd33);
        check({tag, "_busy_fin"}, 64'(bus_raw.o_busy), 64'd0);
        check_result(tag, raw, bcd, ovf);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(bus_raw.o_done), 64'd0);
        check({tag, "_hold"}, bus_raw.o_data, raw);
    endtask

    initial begin
        int  n;
        bit  saw_done;
        n_checks = 0;
        n_errors = 0;
        rstn     = 1'b0;
        drive(1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus_raw.o_busy), 64'd0);
        check("rst_done", 64'(bus_raw.o_done), 64'd0);
        check("rst_ovf", 64'(bus_raw.o_ovf), 64'd0);
        check("rst_data_raw", bus_raw.o_data, 64'hFFFF_FFFF_FFFF_FFC0);
        check("rst_data_bcd", bus_bcd.o_data, 64'h0);
        check("mode_raw", 64'(bus_raw.o_disp_mode), 64'd1);
        check("mode_bcd", 64'(bus_bcd.o_disp_mode), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        run("zero",  32'd0,          64'hFFFF_FFFF_FFFF_FFC0, 64'h0,           1'b0);
        run("12345678", 32'h00BC_614E, 64'hF9A4_B099_9282_F880, 64'h1234_5678, 1'b0);
        run("1005",  32'd1005,       64'hFFFF_FFFF_F9C0_C092, 64'h1005,        1'b0);
        run("max",   32'd99_999_999, 64'h9090_9090_9090_9090, 64'h9999_9999,   1'b0);
        run("ovf",   32'd100_000_000, 64'hBFBF_BFBF_BFBF_BFBF, 64'hFFFF_FFFF,  1'b1);
        run("ovf32", 32'hFFFF_FFFF,  64'hBFBF_BFBF_BFBF_BFBF, 64'hFFFF_FFFF,   1'b1);

        // Reset mid-conversion right after an overflow result.
        @(negedge clk);
        drive(1'b1, 32'd77);
        @(posedge clk);
        #1;
        drive(1'b0, 32'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort_busy", 64'(bus_raw.o_busy), 64'd0);
        check("abort_ovf", 64'(bus_raw.o_ovf), 64'd0);
        check("abort_data_raw", bus_raw.o_data, 64'hFFFF_FFFF_FFFF_FFC0);
        check("abort_data_bcd", bus_bcd.o_data, 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus_raw.o_done || bus_bcd.o_done || bus_raw.o_busy) saw_done = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        // start during CONV is ignored.
        @(negedge clk);
        drive(1'b1, 32'd42);
        @(posedge clk);
        #1;
        drive(1'b0, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        drive(1'b1, 32'd7);
        @(posedge clk);
        #1;
        drive(1'b0, 32'd0);
        wait_done(n);
        check("ignore_latency", 64'(5 + n), 64'd33);
        check_result("ignore", 64'hFFFF_FFFF_FFFF_99A4, 64'h42, 1'b0);

        // Back-to-back with start held high.
        @(negedge clk);
        drive(1'b1, 32'd7);
        @(posedge clk);
        #1;
        wait_done(n);
        check("b2b0_latency", 64'(n), 64'd33);
        check_result("b2b0", 64'hFFFF_FFFF_FFFF_FFF8, 64'h7, 1'b0);
        drive(1'b1, 32'd10_203);
        wait_done(n);
        check("b2b1_period", 64'(n), 64'd34);
        check_result("b2b1", 64'hFFFF_FFF9_C0A4_C0B0, 64'h1_0203, 1'b0);
        drive(1'b1, 32'd5_000_000);
        wait_done(n);
        check("b2b2_period", 64'(n), 64'd34);
        check_result("b2b2", 64'hFF92_C0C0_C0C0_C0C0, 64'h500_0000, 1'b0);
        drive(1'b0, 32'd0);
        @(posedge clk);
        #1;
        check("b2b_idle", 64'(bus_raw.o_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
